// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial A - B - Bin sequencer that time-shares one
// 1-bit full subtractor cell over WIDTH clocks, LSB first, behind a
// start/busy/done handshake. Optional Z/V result flags are enabled by
// defining SERIAL_SUB_FLAGS_EN.
module serial_sub_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Bout
`ifdef SERIAL_SUB_FLAGS_EN
  ,
  output logic             Z,
  output logic             V
`endif
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_s;
  logic             r_bout;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res_sh;
  logic             r_borrow;
  logic [CNT_W-1:0] r_cnt;

  logic             w_cell_a;
  logic             w_cell_b;
  logic             w_cell_s;
  logic             w_cell_bout;
  logic [WIDTH-1:0] w_res_next;

  // 1-bit full subtractor cell fed from the operand LSBs and the borrow chain
  assign w_cell_a    = r_a_sh[0];
  assign w_cell_b    = r_b_sh[0];
  assign w_cell_s    = w_cell_a ^ w_cell_b ^ r_borrow;
  assign w_cell_bout = (~w_cell_a & w_cell_b) | (~(w_cell_a ^ w_cell_b) & r_borrow);

  // Result shift register value including the bit produced this cycle
  assign w_res_next = {w_cell_s, r_res_sh[WIDTH-1:1]};

`ifdef SERIAL_SUB_FLAGS_EN
  logic r_a_msb;
  logic r_b_msb;
  logic r_z;
  logic r_v;

  // Capture operand sign bits on accept; flags update with S on completion
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_z     <= 1'b0;
      r_v     <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && start) begin
        r_a_msb <= A[WIDTH-1];
        r_b_msb <= B[WIDTH-1];
      end
      if (r_state == ST_RUN && r_cnt == LAST_BIT) begin
        r_z <= (w_res_next == '0);
        r_v <= (r_a_msb != r_b_msb) & (w_res_next[WIDTH-1] != r_a_msb);
      end
    end
  end

  assign Z = r_z;
  assign V = r_v;
`endif

  // Sequencer FSM with datapath shift registers and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_s      <= '0;
      r_bout   <= 1'b0;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_res_sh <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a_sh   <= A;
            r_b_sh   <= B;
            r_borrow <= Bin;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
          r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
          r_res_sh <= w_res_next;
          r_borrow <= w_cell_bout;
          if (r_cnt == LAST_BIT) begin
            r_s     <= w_res_next;
            r_bout  <= w_cell_bout;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign S    = r_s;
  assign Bout = r_bout;

endmodule
